// File: rtl/sprite_pkg.sv
// Shared definitions for the animated sprite ROM: facing directions, the transparent
// palette index and the sheet address helper used by both read ports.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int unsigned TRANSPARENT_IDX = 0;

    // Index width that never collapses to zero bits when a dimension is 1.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Word order in the sheet is dir, frame, row, column (column fastest).
    function automatic int unsigned sprite_addr(
        input int unsigned dir,
        input int unsigned frame,
        input int unsigned x,
        input int unsigned y,
        input int unsigned num_frames,
        input int unsigned sprite_w,
        input int unsigned sprite_h
    );
        return ((dir * num_frames + frame) * sprite_h + y) * sprite_w + x;
    endfunction

endpackage

// File: rtl/sprite_rom_dp.sv
// Generic two-read-port synchronous ROM with registered outputs; contents come from
// the initialisation file at configuration time and are never reset.
module sprite_rom_dp #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned DEPTH     = 8192,
    parameter string       INIT_FILE = "./sprite/sprite.mif"
) (
    input  logic                     clock,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    output logic [DATA_W-1:0]        q_a,
    output logic [DATA_W-1:0]        q_b
);

    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/sprite_anim_rom.sv
// Animated sprite sheet: vsync-driven frame sequencer plus two 2-cycle pipelined read
// ports (pixel and collision) sharing one ROM and the same latched frame/direction.
module sprite_anim_rom
    import sprite_pkg::*;
#(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned SPRITE_W   = 32,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned NUM_DIRS   = 4,
    parameter int unsigned NUM_FRAMES = 2,
    parameter int unsigned FRAME_HOLD = 8,
    parameter string       INIT_FILE  = "./sprite/sprite.mif"
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_tick,
    input  logic [idx_w(NUM_DIRS)-1:0]      dir,
    input  logic                            moving,
    input  logic                            px_req,
    input  logic [idx_w(SPRITE_W)-1:0]      px_x,
    input  logic [idx_w(SPRITE_H)-1:0]      px_y,
    output logic [DATA_W-1:0]               px_q,
    output logic                            px_valid,
    input  logic                            col_req,
    input  logic [idx_w(SPRITE_W)-1:0]      col_x,
    input  logic [idx_w(SPRITE_H)-1:0]      col_y,
    output logic [DATA_W-1:0]               col_q,
    output logic                            col_valid,
    output logic [idx_w(NUM_FRAMES)-1:0]    cur_frame,
    output logic [idx_w(NUM_DIRS)-1:0]      cur_dir
);

    localparam int unsigned DEPTH = NUM_DIRS * NUM_FRAMES * SPRITE_W * SPRITE_H;
    localparam int unsigned AW    = idx_w(DEPTH);
    localparam int unsigned FW    = idx_w(NUM_FRAMES);
    localparam int unsigned HW    = idx_w(FRAME_HOLD);

    logic [idx_w(NUM_DIRS)-1:0] dir_l;
    logic [FW-1:0]              frame;
    logic [HW-1:0]              hold_cnt;

    // State only moves on frame_tick so a video frame never mixes two images.
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_l    <= '0;
            frame    <= '0;
            hold_cnt <= '0;
        end else if (frame_tick) begin
            dir_l <= dir;
            if (dir != dir_l || !moving) begin
                frame    <= '0;
                hold_cnt <= '0;
            end else if (32'(hold_cnt) == FRAME_HOLD - 1) begin
                hold_cnt <= '0;
                frame    <= (32'(frame) == NUM_FRAMES - 1) ? '0 : frame + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign cur_frame = frame;
    assign cur_dir   = dir_l;

    logic [AW-1:0] px_addr, col_addr;
    logic          px_oob, col_oob;

    always_comb begin
        px_oob   = (32'(px_x) >= SPRITE_W) || (32'(px_y) >= SPRITE_H);
        col_oob  = (32'(col_x) >= SPRITE_W) || (32'(col_y) >= SPRITE_H);
        px_addr  = '0;
        col_addr = '0;
        if (!px_oob) begin
            px_addr = AW'(sprite_addr(32'(dir_l), 32'(frame), 32'(px_x), 32'(px_y),
                                      NUM_FRAMES, SPRITE_W, SPRITE_H));
        end
        if (!col_oob) begin
            col_addr = AW'(sprite_addr(32'(dir_l), 32'(frame), 32'(col_x), 32'(col_y),
                                       NUM_FRAMES, SPRITE_W, SPRITE_H));
        end
    end

    logic [AW-1:0]     px_addr_s1, col_addr_s1;
    logic              px_oob_s1, col_oob_s1, px_oob_s2, col_oob_s2;
    logic              px_vld_s1, col_vld_s1, px_vld_s2, col_vld_s2;
    logic              px_has, col_has;
    logic [DATA_W-1:0] px_rom_q, col_rom_q;

    // Stage-1 registers load only on a request, so the ROM keeps re-reading the
    // last requested word and the result holds until the next valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            px_addr_s1  <= '0;
            col_addr_s1 <= '0;
            px_oob_s1   <= 1'b0;
            col_oob_s1  <= 1'b0;
            px_oob_s2   <= 1'b0;
            col_oob_s2  <= 1'b0;
            px_vld_s1   <= 1'b0;
            col_vld_s1  <= 1'b0;
            px_vld_s2   <= 1'b0;
            col_vld_s2  <= 1'b0;
            px_has      <= 1'b0;
            col_has     <= 1'b0;
        end else begin
            px_vld_s1  <= px_req;
            col_vld_s1 <= col_req;
            px_vld_s2  <= px_vld_s1;
            col_vld_s2 <= col_vld_s1;
            px_oob_s2  <= px_oob_s1;
            col_oob_s2 <= col_oob_s1;
            if (px_req) begin
                px_addr_s1 <= px_addr;
                px_oob_s1  <= px_oob;
            end
            if (col_req) begin
                col_addr_s1 <= col_addr;
                col_oob_s1  <= col_oob;
            end
            if (px_vld_s1) px_has <= 1'b1;
            if (col_vld_s1) col_has <= 1'b1;
        end
    end

    sprite_rom_dp #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clock  (clock),
        .addr_a (px_addr_s1),
        .addr_b (col_addr_s1),
        .q_a    (px_rom_q),
        .q_b    (col_rom_q)
    );

    always_comb begin
        px_q  = '0;
        col_q = '0;
        if (px_has) px_q = px_oob_s2 ? DATA_W'(TRANSPARENT_IDX) : px_rom_q;
        if (col_has) col_q = col_oob_s2 ? DATA_W'(TRANSPARENT_IDX) : col_rom_q;
    end

    assign px_valid  = px_vld_s2;
    assign col_valid = col_vld_s2;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Directed bench for sprite_anim_rom: table of tick/read vectors plus hand-written
// sequences for pipelining, tick-cycle reads and reset squashing.
module tb_sprite_anim_rom;
    import sprite_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] dir = 2'd0;
    logic       moving = 1'b0;
    logic       px_req = 1'b0;
    logic       col_req = 1'b0;
    logic [4:0] px_x = '0, px_y = '0, col_x = '0, col_y = '0;
    logic [3:0] px_q, col_q;
    logic       px_valid, col_valid;
    logic [0:0] cur_frame;
    logic [1:0] cur_dir;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sprite_anim_rom dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .dir        (dir),
        .moving     (moving),
        .px_req     (px_req),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_q       (px_q),
        .px_valid   (px_valid),
        .col_req    (col_req),
        .col_x      (col_x),
        .col_y      (col_y),
        .col_q      (col_q),
        .col_valid  (col_valid),
        .cur_frame  (cur_frame),
        .cur_dir    (cur_dir)
    );

    // Contents fold row and dir/frame bits into the low nibble so that reads from
    // different frames or directions at the same x are distinguishable.
    function automatic int mem_val(input int a);
        return (a ^ (a >> 5) ^ (a >> 10)) & 15;
    endfunction

    function automatic int exp_px(input int d, input int f, input int x, input int y);
        return mem_val(((d * 2 + f) * 32 + y) * 32 + x);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input logic [1:0] d, input logic m);
        dir = d;
        moving = m;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic read_px(input string name, input int x, input int y, input int exp);
        px_x = 5'(x);
        px_y = 5'(y);
        px_req = 1'b1;
        step();
        px_req = 1'b0;
        chk({name, " early"}, int'(px_valid), 0);
        step();
        chk({name, " valid"}, int'(px_valid), 1);
        chk({name, " data"}, int'(px_q), exp);
        step();
        chk({name, " single"}, int'(px_valid), 0);
        chk({name, " hold"}, int'(px_q), exp);
    endtask

    typedef struct {
        logic [1:0] dir;
        logic       moving;
        int         n;
        int         exp_frame;
        int         exp_dir;
        int         x;
        int         y;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{DIR_RIGHT, 1'b0, 1, 0, 1, 0, 0};
        vecs[1]  = '{DIR_RIGHT, 1'b1, 7, 0, 1, 5, 0};
        vecs[2]  = '{DIR_RIGHT, 1'b1, 1, 1, 1, 0, 0};
        vecs[3]  = '{DIR_RIGHT, 1'b1, 8, 0, 1, 5, 0};
        vecs[4]  = '{DIR_RIGHT, 1'b1, 8, 1, 1, 9, 4};
        vecs[5]  = '{DIR_RIGHT, 1'b0, 1, 0, 1, 2, 3};
        vecs[6]  = '{DIR_RIGHT, 1'b1, 7, 0, 1, 6, 1};
        vecs[7]  = '{DIR_RIGHT, 1'b1, 1, 1, 1, 6, 1};
        vecs[8]  = '{DIR_UP,    1'b1, 1, 0, 2, 11, 8};
        vecs[9]  = '{DIR_UP,    1'b1, 8, 1, 2, 31, 31};
        vecs[10] = '{DIR_LEFT,  1'b1, 1, 0, 3, 17, 12};

        #1;
        for (int a = 0; a < 8192; a++) dut.u_rom.mem[a] = 4'(mem_val(a));

        step();
        step();
        chk("reset px_q", int'(px_q), 0);
        chk("reset px_valid", int'(px_valid), 0);
        chk("reset col_q", int'(col_q), 0);
        chk("reset col_valid", int'(col_valid), 0);
        chk("reset cur_frame", int'(cur_frame), 0);
        chk("reset cur_dir", int'(cur_dir), 0);
        reset = 1'b0;
        step();

        read_px("first read", 3, 2, exp_px(0, 0, 3, 2));

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].dir, vecs[i].moving);
            chk($sformatf("vec%0d cur_frame", i), int'(cur_frame), vecs[i].exp_frame);
            chk($sformatf("vec%0d cur_dir", i), int'(cur_dir), vecs[i].exp_dir);
            read_px($sformatf("vec%0d read", i), vecs[i].x, vecs[i].y,
                    exp_px(vecs[i].exp_dir, vecs[i].exp_frame, vecs[i].x, vecs[i].y));
        end

        // Direction change without a tick must not reach cur_dir.
        dir = DIR_DOWN;
        step();
        step();
        chk("no tick cur_dir", int'(cur_dir), 3);
        dir = DIR_LEFT;

        // Back-to-back pixel reads with a fixed collision probe alongside.
        for (int c = 0; c < 34; c++) begin
            px_req  = (c < 32);
            col_req = (c < 32);
            px_x    = 5'(c);
            px_y    = 5'd1;
            col_x   = 5'd7;
            col_y   = 5'd7;
            step();
            if (c >= 1 && c <= 32) begin
                chk($sformatf("burst px_valid %0d", c - 1), int'(px_valid), 1);
                chk($sformatf("burst px_q %0d", c - 1), int'(px_q), exp_px(3, 0, c - 1, 1));
                chk($sformatf("burst col_valid %0d", c - 1), int'(col_valid), 1);
                chk($sformatf("burst col_q %0d", c - 1), int'(col_q), exp_px(3, 0, 7, 7));
            end else if (c == 33) begin
                chk("burst px_valid end", int'(px_valid), 0);
            end
        end
        px_req  = 1'b0;
        col_req = 1'b0;

        // Request in the tick cycle that advances the frame uses the old frame.
        for (int k = 0; k < 7; k++) tick(DIR_LEFT, 1'b1);
        px_x = 5'd4;
        px_y = 5'd6;
        col_x = 5'd4;
        col_y = 5'd6;
        px_req = 1'b1;
        col_req = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        px_req = 1'b0;
        col_req = 1'b0;
        chk("tick-cycle cur_frame", int'(cur_frame), 1);
        step();
        chk("tick-cycle px_valid", int'(px_valid), 1);
        chk("tick-cycle px_q", int'(px_q), exp_px(3, 0, 4, 6));
        chk("tick-cycle col_valid", int'(col_valid), 1);
        chk("tick-cycle col_q", int'(col_q), exp_px(3, 0, 4, 6));
        read_px("new frame read", 4, 6, exp_px(3, 1, 4, 6));

        // Reset one cycle after a request squashes it.
        px_x = 5'd1;
        px_y = 5'd1;
        col_x = 5'd2;
        col_y = 5'd2;
        px_req = 1'b1;
        col_req = 1'b1;
        step();
        px_req = 1'b0;
        col_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("squash px_valid", int'(px_valid), 0);
        chk("squash col_valid", int'(col_valid), 0);
        chk("squash px_q", int'(px_q), 0);
        chk("squash col_q", int'(col_q), 0);
        chk("squash cur_frame", int'(cur_frame), 0);
        chk("squash cur_dir", int'(cur_dir), 0);
        step();
        chk("squash px_valid late", int'(px_valid), 0);
        chk("squash col_valid late", int'(col_valid), 0);

        read_px("post-reset read", 8, 9, exp_px(0, 0, 8, 9));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
